// File: rtl/seq_detector_param_if.sv
// Serial-in / status-out bundle for the parametrised sequence detector.
// The master drives en/din. The slave, which is the detector, returns its state and match status.
interface seq_detector_param_if #(
  parameter int SW    = 3,
  parameter int CNT_W = 8
);
  logic             en;
  logic             din;
  logic [SW-1:0]    state;
  logic [SW-1:0]    next_state;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, din,
    input  state, next_state, y, match_cnt, cnt_sat
  );

  modport slave (
    input  en, din,
    output state, next_state, y, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with a KMP-style fallback.
// State k means the last k consumed bits equal the first k pattern bits.
// The transition table is built from the parameters at elaboration.
// There is one table entry per (state, din) pair.
// The match counter saturates at its maximum value.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  parameter int                 SW      = $clog2(PAT_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  // Next state from state s on bit b.
  // The result is the longest suffix of (prefix(s), b) that is also a pattern prefix.
  // In non-overlap mode, the full-match state restarts as if it were state 0.
  function automatic int calc_next(input int s, input int b);
    logic [PAT_LEN:0] w;
    int               len;
    int               res;
    logic             ok;
    res = 0;
    w   = '0;
    if (s == PAT_LEN && !OVERLAP) begin
      res = (b[0] == PATTERN[PAT_LEN-1]) ? 1 : 0;
    end else begin
      for (int i = 0; i < PAT_LEN; i++)
        if (i < s) w[i] = PATTERN[PAT_LEN-1-i];
      w[s] = b[0];
      len  = s + 1;
      // Try increasing lengths; the last hit is the longest suffix/prefix match.
      for (int k = 1; k <= PAT_LEN; k++) begin
        if (k <= len) begin
          ok = 1'b1;
          for (int j = 0; j < PAT_LEN; j++) begin
            if (j < k) begin
              if (w[len-k+j] != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
            end
          end
          if (ok) res = k;
        end
      end
    end
    return res;
  endfunction

  // The table covers every encodable state.
  // Codes above PAT_LEN are unreachable and fall back to 0.
  logic [SW-1:0] tbl [2**SW][2];

  for (genvar gs = 0; gs < 2**SW; gs++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      localparam int NS = (gs <= PAT_LEN) ? calc_next(gs, gb) : 0;
      assign tbl[gs][gb] = SW'(NS);
    end
  end

  logic [CNT_W-1:0] cnt_nx;

  // Next-state lookup.
  // Holding en low freezes the detector.
  always_comb begin
    bus.next_state = bus.state;
    if (bus.en) bus.next_state = tbl[bus.state][bus.din];
  end

  // Saturating increment on every consumed bit that completes a match.
  always_comb begin
    cnt_nx = bus.match_cnt;
    if (bus.en && (bus.next_state == SW'(PAT_LEN)) && !(&bus.match_cnt))
      cnt_nx = bus.match_cnt + 1'b1;
  end

  // State, counter and registered decode of y/cnt_sat.
  // Reset takes priority over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.state     <= '0;
      bus.y         <= 1'b0;
      bus.match_cnt <= '0;
      bus.cnt_sat   <= 1'b0;
    end else begin
      bus.state     <= bus.next_state;
      bus.y         <= (bus.next_state == SW'(PAT_LEN));
      bus.match_cnt <= cnt_nx;
      bus.cnt_sat   <= &cnt_nx;
    end
  end

endmodule
